rr_mux4_arbiter: RTL and testbench
==================================

# rr_mux4_arbiter

Round-robin arbiter and select sequencer for the 4:1 one-bit multiplexer datapath. Four requesters share a single one-bit output channel. The block grants the channel to one requester at a time, drives the 2-bit select of an embedded `MUX_4` instance, and gates the routed bit. A hold counter limits each grant to at most `MAX_HOLD` cycles so that no requester can starve the others.

## Interface
Parameters:
- `MAX_HOLD`, default 4: maximum consecutive cycles in one grant. Legal range is 1..15; the counter is 4 bits.

Ports:
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req`  in  4: request per requester; `req[i]` = requester i wants the channel.
- `din`  in  4: data bit per requester; routed through the embedded `MUX_4` as `I`.
- `gnt`  out 4: one-hot grant (registered); all-zero when idle.
- `sel`  out 2: registered select driven to `MUX_4.S`; index of current or last grantee.
- `dout` out 1: `din[sel]` while `busy`=1, else 0. Combinational from `MUX_4.Y` gated by `busy`.
- `busy` out 1: registered; 1 while any grant is active.

## Operation
- State machine, two states:
  - `IDLE`: `gnt`=0, `busy`=0.
  - `GRANT`: exactly one `gnt` bit set, `busy`=1.
- Internal state: `ptr[1:0]`, the search start index, and `cnt[3:0]`, the hold counter.
- Winner selection:
  - Search `req` starting at index `ptr`, then `ptr+1`, `ptr+2`, `ptr+3`, all mod 4.
  - The first set bit wins.
  - Purely combinational priority rotate; no masking beyond the rotation.
- `IDLE` transition: if `req`≠0 at the edge, go to `GRANT` with:
  - `sel`=winner
  - `gnt`=1<<winner
  - `cnt`=1
  - Otherwise remain in `IDLE`.
- `GRANT` at each edge:
  - Release condition: `req[sel]`=0 or `cnt`==`MAX_HOLD`.
  - No release: `cnt`←`cnt`+1; `gnt` and `sel` unchanged.
  - Release: `ptr`←`sel`+1 (mod 4, wraps 3→0). Then re-arbitrate in the same edge, using the new `ptr` over the current `req`:
    - If any `req` is set, grant the new winner directly, with `cnt`=1 and no idle bubble.
    - Otherwise go to `IDLE`.
  - The outgoing requester may win again only if no other requester is pending, because it now has the lowest priority.
- `sel` keeps its last value in `IDLE`. `dout` is forced to 0 in `IDLE` regardless of `din`.
- `din` is not sampled; it is routed combinationally only.

## Timing
- Reset values: `gnt`=4'b0000, `sel`=2'b00, `busy`=0, `dout`=0, `ptr`=0, `cnt`=0, state `IDLE`.
- Grant latency is one cycle: `req` sampled high at edge k gives `gnt` and `busy` valid after edge k.
- Maximum grant length is `MAX_HOLD` cycles. With `MAX_HOLD`=1, the grant rotates every cycle.
- Drop timing: `gnt` stays high during the cycle in which the grantee drops `req`. It falls at the next edge, so there is one cycle of grant overhang.
- Handover between requesters is zero-bubble: `gnt` switches one-hot to one-hot in a single edge and `busy` stays 1.
- Simultaneous requests are resolved by `ptr` rotation only. Each of four continuously requesting agents is served once per 4 grants.
- Reset mid-grant: the next edge after `rst`=1 forces all reset values and discards `ptr` history.
- `dout` follows `din[sel]` combinationally within the cycle.
- `gnt` is never multi-hot and never X after reset.

## Test plan
- **Reset:** `rst`=1 for 2 cycles with `req`=4'b1111 → `gnt`=0, `busy`=0, `sel`=0, `dout`=0 throughout; first grant after release of `rst` is `gnt`=4'b0001.
- **Single request:** `req`=4'b0100 held → `gnt`=4'b0100, `sel`=2, `dout`=`din[2]` one cycle later. With `MAX_HOLD`=4, the grant is re-issued to requester 2 after 4 cycles, with no bubble.
- **Full contention:** `req`=4'b1111 held, `MAX_HOLD`=4 → grants 0,1,2,3,0 each exactly 4 cycles; `busy` never drops.
- **Early drop:** grantee 1 drops `req` after 2 granted cycles, while `req[3]` is pending → `gnt[1]` high 3 cycles (including overhang), then `gnt`=4'b1000 directly, then `ptr`=2.
- **Wrap and idle:** grant to 3 released with `req`=0 → `IDLE`, `dout`=0, `sel` stays 3; then `req`=4'b1001 → grant 0, because `ptr` wrapped to 0.
- **Mid-grant reset plus data routing:** toggle `din` with periods 2/4/8/16 cycles during a grant to requester 2 → `dout` matches `din[2]` every cycle; assert `rst` → next edge gives `gnt`=0, `dout`=0.

Source files
------------

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter for four requesters sharing a one-bit channel.
// Drives the select of an embedded 4:1 mux and gates the routed bit with busy.

module MUX_4 (
  input  logic [3:0] I,
  input  logic [1:0] S,
  output logic       Y
);
  assign Y = I[S];
endmodule

module rr_mux4_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] din,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       dout,
  output logic       busy
);

  localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] gnt_q, gnt_d;
  logic       busy_q, busy_d;

  logic       release_grant;
  logic       any_req;
  logic [1:0] arb_ptr;
  logic [1:0] winner;
  logic       mux_y;

  assign any_req = |req;

  // A releasing grantee moves the search start past itself in the same edge,
  // so the winner is computed from the post-release pointer.
  assign release_grant = (state_q == GRANT) && (!req[sel_q] || (cnt_q == HOLD_LIM));
  assign arb_ptr       = release_grant ? (sel_q + 2'd1) : ptr_q;

  always_comb begin
    logic [1:0] idx;
    winner = arb_ptr;
    idx    = arb_ptr;
    // Scan from the farthest offset down so the nearest requester wins last.
    for (int k = 3; k >= 0; k--) begin
      idx = arb_ptr + 2'(k);
      if (req[idx]) begin
        winner = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = GRANT;
          sel_d   = winner;
          gnt_d   = 4'b0001 << winner;
          cnt_d   = 4'd1;
          busy_d  = 1'b1;
        end
      end
      GRANT: begin
        if (!release_grant) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          ptr_d = sel_q + 2'd1;
          if (any_req) begin
            sel_d  = winner;
            gnt_d  = 4'b0001 << winner;
            cnt_d  = 4'd1;
            busy_d = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            cnt_d   = 4'd0;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      cnt_q   <= 4'd0;
      sel_q   <= 2'd0;
      gnt_q   <= 4'b0000;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

  MUX_4 u_mux (
    .I (din),
    .S (sel_q),
    .Y (mux_y)
  );

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = busy_q;
  assign dout = mux_y & busy_q;

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Directed bench for rr_mux4_arbiter with MAX_HOLD=4: table of per-cycle
// vectors plus hand sequences for early drop, data routing and mid-grant reset.

module tb_rr_mux4_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] din;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       dout;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int step_no = 0;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       dout;
  } vec_t;

  vec_t vq[$];

  rr_mux4_arbiter #(.MAX_HOLD(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .din  (din),
    .gnt  (gnt),
    .sel  (sel),
    .dout (dout),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s step %0d: got %b expected %b", name, step_no, act, exp_v);
    end
  endtask

  task automatic apply(input logic r, input logic [3:0] rq, input logic [3:0] dn,
                       input logic [3:0] eg, input logic [1:0] es, input logic eb,
                       input logic ed);
    rst = r;
    req = rq;
    din = dn;
    @(posedge clk);
    #1;
    $display("step %0d rst=%b req=%b din=%b -> gnt=%b sel=%0d busy=%b dout=%b",
             step_no, r, rq, dn, gnt, sel, busy, dout);
    check("gnt", gnt, eg);
    check("sel", {2'b00, sel}, {2'b00, es});
    check("busy", {3'b000, busy}, {3'b000, eb});
    check("dout", {3'b000, dout}, {3'b000, ed});
    step_no++;
  endtask

  task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] dn,
                     input logic [3:0] eg, input logic [1:0] es, input logic eb,
                     input logic ed);
    vec_t v;
    v.rst = r; v.req = rq; v.din = dn;
    v.gnt = eg; v.sel = es; v.busy = eb; v.dout = ed;
    vq.push_back(v);
  endtask

  initial begin
    logic [3:0] t4;
    rst = 1'b1;
    req = 4'b0000;
    din = 4'b0000;

    // Reset held with all requesting, then full contention 0,1,2,3,0
    add(1, 4'b1111, 4'b1111, 4'b0000, 2'd0, 0, 0);
    add(1, 4'b1111, 4'b1111, 4'b0000, 2'd0, 0, 0);
    add(0, 4'b1111, 4'b0101, 4'b0001, 2'd0, 1, 1);
    add(0, 4'b1111, 4'b0100, 4'b0001, 2'd0, 1, 0);
    add(0, 4'b1111, 4'b0101, 4'b0001, 2'd0, 1, 1);
    add(0, 4'b1111, 4'b0100, 4'b0001, 2'd0, 1, 0);
    add(0, 4'b1111, 4'b0010, 4'b0010, 2'd1, 1, 1);
    add(0, 4'b1111, 4'b0000, 4'b0010, 2'd1, 1, 0);
    add(0, 4'b1111, 4'b0010, 4'b0010, 2'd1, 1, 1);
    add(0, 4'b1111, 4'b1101, 4'b0010, 2'd1, 1, 0);
    add(0, 4'b1111, 4'b0100, 4'b0100, 2'd2, 1, 1);
    add(0, 4'b1111, 4'b1011, 4'b0100, 2'd2, 1, 0);
    add(0, 4'b1111, 4'b0100, 4'b0100, 2'd2, 1, 1);
    add(0, 4'b1111, 4'b0000, 4'b0100, 2'd2, 1, 0);
    add(0, 4'b1111, 4'b1000, 4'b1000, 2'd3, 1, 1);
    add(0, 4'b1111, 4'b0111, 4'b1000, 2'd3, 1, 0);
    add(0, 4'b1111, 4'b1000, 4'b1000, 2'd3, 1, 1);
    add(0, 4'b1111, 4'b1000, 4'b1000, 2'd3, 1, 1);
    add(0, 4'b1111, 4'b0001, 4'b0001, 2'd0, 1, 1);
    // Hand over to 3, release with nothing pending, idle with sel held at 3
    add(0, 4'b1000, 4'b1000, 4'b1000, 2'd3, 1, 1);
    add(0, 4'b0000, 4'b1111, 4'b0000, 2'd3, 0, 0);
    add(0, 4'b0000, 4'b1111, 4'b0000, 2'd3, 0, 0);
    // Pointer wrapped to 0, so 0 beats 3
    add(0, 4'b1001, 4'b1110, 4'b0001, 2'd0, 1, 0);
    // Single requester 2: re-granted after 4 cycles with no bubble
    add(0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1, 1);
    add(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1, 0);
    add(0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1, 1);
    add(0, 4'b0100, 4'b1011, 4'b0100, 2'd2, 1, 0);
    add(0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1, 1);
    add(0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1, 1);

    for (int i = 0; i < vq.size(); i++) begin
      apply(vq[i].rst, vq[i].req, vq[i].din, vq[i].gnt, vq[i].sel, vq[i].busy, vq[i].dout);
    end

    // Early drop: grantee 1 holds 2 cycles, drops during the third, 3 pending
    apply(0, 4'b0010, 4'b0010, 4'b0010, 2'd1, 1, 1);
    apply(0, 4'b1010, 4'b0000, 4'b0010, 2'd1, 1, 0);
    apply(0, 4'b1010, 4'b0010, 4'b0010, 2'd1, 1, 1);
    apply(0, 4'b1000, 4'b0010, 4'b1000, 2'd3, 1, 0);
    check("ptr", {2'b00, dut.ptr_q}, 4'd2);

    // Data routing: din bits toggle with periods 2/4/8/16 during grant to 2
    for (int t = 0; t < 16; t++) begin
      t4 = 4'(t);
      apply(0, 4'b0100, t4, 4'b0100, 2'd2, 1, t4[2]);
    end

    // Mid-grant reset clears everything including pointer history
    apply(1, 4'b0100, 4'b1111, 4'b0000, 2'd0, 0, 0);
    apply(0, 4'b1111, 4'b0001, 4'b0001, 2'd0, 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
